// File: rtl/crash_course_cpu_program_sequencer_if.sv
// Request/strobe bundle between the instruction decoder, the call stack and
// the crash-course CPU program sequencer. The master side issues decoded
// requests. The slave side is the sequencer, which returns PC, strobes and status.
interface crash_course_cpu_program_sequencer_if;
    logic       clk_en;
    logic       jump_request;
    logic       call_request;
    logic       return_request;
    logic       condition_met;
    logic [7:0] jump_target;
    logic [7:0] return_address;
    logic       halt_request;
    logic       resume_request;
    logic [7:0] program_counter_current;
    logic       jump_enable;
    logic       call_enable;
    logic       return_enable;
    logic [3:0] stack_depth;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output clk_en, jump_request, call_request, return_request, condition_met,
               jump_target, return_address, halt_request, resume_request,
        input  program_counter_current, jump_enable, call_enable, return_enable,
               stack_depth, fault, fault_code
    );

    modport slave (
        input  clk_en, jump_request, call_request, return_request, condition_met,
               jump_target, return_address, halt_request, resume_request,
        output program_counter_current, jump_enable, call_enable, return_enable,
               stack_depth, fault, fault_code
    );
endinterface

// File: rtl/crash_course_cpu_program_sequencer.sv
// Program-counter sequencer for the crash-course CPU.
// This block owns the 8-bit PC and issues the jump, call and return strobes for the call stack.
// It also tracks the call depth.
// Build option: define CALL_STACK_GUARD_EN to compile in overflow/underflow/
// call+return fault detection (FAULT state, fault/fault_code outputs).
// Without it, the fault outputs are tied low, depth saturates, and the sequencer
// drops a simultaneous call+return.
module crash_course_cpu_program_sequencer #(
    parameter int STACK_DEPTH = 8
) (
    input  logic clk,
    input  logic async_rst,
    crash_course_cpu_program_sequencer_if.slave bus
);

    localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

`ifdef CALL_STACK_GUARD_EN
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1
    } state_t;
`endif

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] pc_r;
    logic [7:0] pc_next_s;
    logic [3:0] depth_r;
    logic [3:0] depth_next_s;
    logic       run_s;
    logic       both_s;
    logic       legal_s;
    logic       go_s;
    logic       call_s;
    logic       ret_s;
    logic       jmp_s;
`ifdef CALL_STACK_GUARD_EN
    logic       overflow_s;
    logic       underflow_s;
    logic [1:0] fault_code_r;
    logic [1:0] fault_code_next_s;
`endif

    // Classify this cycle's request: legality and whether a transfer may be taken
    always_comb begin
        run_s  = (state_r == ST_RUN);
        both_s = bus.call_request & bus.return_request;
`ifdef CALL_STACK_GUARD_EN
        overflow_s  = bus.call_request & bus.condition_met & (depth_r == DEPTH_MAX);
        underflow_s = bus.return_request & bus.condition_met & (depth_r == 4'd0);
        legal_s     = ~(overflow_s | underflow_s | both_s);
`else
        legal_s     = ~both_s;
`endif
        go_s = run_s & ~bus.halt_request & legal_s;
    end

    // State register
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: illegal request beats halt, which beats any transfer
    always_comb begin
        next_state_s = state_r;
        if (bus.clk_en) begin
            case (state_r)
                ST_RUN: begin
`ifdef CALL_STACK_GUARD_EN
                    if (!legal_s) begin
                        next_state_s = ST_FAULT;
                    end else if (bus.halt_request) begin
                        next_state_s = ST_HALT;
                    end else begin
                        next_state_s = ST_RUN;
                    end
`else
                    if (bus.halt_request) begin
                        next_state_s = ST_HALT;
                    end else begin
                        next_state_s = ST_RUN;
                    end
`endif
                end
                ST_HALT: begin
                    if (bus.resume_request) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_HALT;
                    end
                end
`ifdef CALL_STACK_GUARD_EN
                ST_FAULT: next_state_s = ST_FAULT;
                default:  next_state_s = ST_FAULT;
`else
                default:  next_state_s = ST_RUN;
`endif
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Output logic: combinational transfer strobes, valid in the request cycle
    always_comb begin
        call_s = go_s & bus.call_request & bus.condition_met;
        ret_s  = go_s & bus.return_request & bus.condition_met;
        jmp_s  = call_s | ret_s | (go_s & bus.jump_request & bus.condition_met);
    end

    assign bus.call_enable             = call_s;
    assign bus.return_enable           = ret_s;
    assign bus.jump_enable             = jmp_s;
    assign bus.program_counter_current = pc_r;
    assign bus.stack_depth             = depth_r;
`ifdef CALL_STACK_GUARD_EN
    assign bus.fault                   = (state_r == ST_FAULT);
    assign bus.fault_code              = fault_code_r;
`else
    assign bus.fault                   = 1'b0;
    assign bus.fault_code              = 2'b00;
`endif

    // PC, depth and fault-cause next values; everything holds outside enabled RUN
    always_comb begin
        pc_next_s    = pc_r;
        depth_next_s = depth_r;
`ifdef CALL_STACK_GUARD_EN
        fault_code_next_s = fault_code_r;
`endif
        if (bus.clk_en && run_s) begin
`ifdef CALL_STACK_GUARD_EN
            if (!legal_s) begin
                // Simultaneous call+return is reported ahead of a depth fault.
                if (both_s) begin
                    fault_code_next_s = 2'd3;
                end else if (overflow_s) begin
                    fault_code_next_s = 2'd1;
                end else begin
                    fault_code_next_s = 2'd2;
                end
            end else
`endif
            if (bus.halt_request) begin
                pc_next_s = pc_r;
            end else if (ret_s) begin
                pc_next_s    = bus.return_address;
                depth_next_s = (depth_r == 4'd0) ? 4'd0 : (depth_r - 4'd1);
            end else if (call_s) begin
                pc_next_s    = bus.jump_target;
                depth_next_s = (depth_r == DEPTH_MAX) ? DEPTH_MAX : (depth_r + 4'd1);
            end else if (jmp_s) begin
                pc_next_s = bus.jump_target;
            end else begin
                pc_next_s = pc_r + 8'd1;
            end
        end else begin
            pc_next_s    = pc_r;
            depth_next_s = depth_r;
        end
    end

    // PC, depth and fault-cause registers
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            pc_r         <= 8'h00;
            depth_r      <= 4'd0;
`ifdef CALL_STACK_GUARD_EN
            fault_code_r <= 2'd0;
`endif
        end else begin
            pc_r         <= pc_next_s;
            depth_r      <= depth_next_s;
`ifdef CALL_STACK_GUARD_EN
            fault_code_r <= fault_code_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_crash_course_cpu_program_sequencer.sv
// Scoreboard bench for crash_course_cpu_program_sequencer. The stimulus side
// runs a behavioural sequencer model and queues the expected cycle response.
// A monitor pops that response on the falling edge and compares it.
// Honors CALL_STACK_GUARD_EN the same way the design does.
module tb_crash_course_cpu_program_sequencer;

    localparam int SD      = 8;
    localparam int M_RUN   = 0;
    localparam int M_HALT  = 1;
    localparam int M_FAULT = 2;

    typedef struct {
        logic [7:0] pc;
        logic [3:0] depth;
        logic       fault;
        logic [1:0] code;
        logic       je;
        logic       ce;
        logic       re;
    } exp_t;

    logic clk;
    logic async_rst;
    crash_course_cpu_program_sequencer_if bus ();

    crash_course_cpu_program_sequencer #(.STACK_DEPTH(SD)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .bus       (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_pc = 0;
    int   m_depth = 0;
    int   m_mode = M_RUN;
    int   m_code = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each presented cycle against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc",          {24'd0, bus.program_counter_current}, {24'd0, e.pc});
            check("depth",       {28'd0, bus.stack_depth},             {28'd0, e.depth});
            check("fault",       {31'd0, bus.fault},                   {31'd0, e.fault});
            check("fault_code",  {30'd0, bus.fault_code},              {30'd0, e.code});
            check("jump_enable", {31'd0, bus.jump_enable},             {31'd0, e.je});
            check("call_enable", {31'd0, bus.call_enable},             {31'd0, e.ce});
            check("ret_enable",  {31'd0, bus.return_enable},           {31'd0, e.re});
        end
    end

    task automatic drive_idle();
        bus.clk_en = 1'b0; bus.jump_request = 1'b0; bus.call_request = 1'b0;
        bus.return_request = 1'b0; bus.condition_met = 1'b0; bus.halt_request = 1'b0;
        bus.resume_request = 1'b0; bus.jump_target = 8'h00; bus.return_address = 8'h00;
    endtask

    // Assert reset mid-cycle and check that it acts without a clock edge
    task automatic do_reset();
        exp_t e;
        @(posedge clk); #1;
        drive_idle();
        async_rst = 1'b1;
        #2;
        check("rst_pc",    {24'd0, bus.program_counter_current}, 32'h0);
        check("rst_depth", {28'd0, bus.stack_depth},             32'h0);
        check("rst_fault", {31'd0, bus.fault},                   32'h0);
        m_pc = 0; m_depth = 0; m_mode = M_RUN; m_code = 0;
        e.pc = 8'h00; e.depth = 4'd0; e.fault = 1'b0; e.code = 2'd0;
        e.je = 1'b0; e.ce = 1'b0; e.re = 1'b0;
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus, with the expected response queued for the monitor
    task automatic step(input bit en, input bit jr, input bit cr, input bit rr, input bit cm,
                        input bit ht, input bit rs, input logic [7:0] tgt, input logic [7:0] ra);
        exp_t e;
        bit   c, r, j, ill;
        int   code;
        @(posedge clk); #1;
        async_rst = 1'b0;
        bus.clk_en = en; bus.jump_request = jr; bus.call_request = cr;
        bus.return_request = rr; bus.condition_met = cm; bus.halt_request = ht;
        bus.resume_request = rs; bus.jump_target = tgt; bus.return_address = ra;
        e.pc = 8'(m_pc); e.depth = 4'(m_depth); e.fault = (m_mode == M_FAULT);
        e.code = 2'(m_code);
        c = 1'b0; r = 1'b0; j = 1'b0;
        if (m_mode == M_RUN) begin
`ifdef CALL_STACK_GUARD_EN
            ill  = (cr && rr) || (cr && cm && m_depth == SD) || (rr && cm && m_depth == 0);
            code = (cr && rr) ? 3 : ((cr && cm && m_depth == SD) ? 1 : 2);
            if (ill) begin
                if (en) begin m_mode = M_FAULT; m_code = code; end
            end else if (ht) begin
                if (en) m_mode = M_HALT;
            end
`else
            ill  = cr && rr;
            code = 0;
            if (ht) begin
                if (en) m_mode = M_HALT;
            end else if (ill) begin
                if (en) m_pc = (m_pc + code + 1) % 256;
            end
`endif
            else begin
                c = cr && cm;
                r = rr && cm;
                j = c || r || (jr && cm);
                if (en) begin
                    if (r)      m_pc = int'(ra);
                    else if (j) m_pc = int'(tgt);
                    else        m_pc = (m_pc + 1) % 256;
                    if (c) m_depth = (m_depth < SD) ? m_depth + 1 : SD;
                    if (r) m_depth = (m_depth > 0) ? m_depth - 1 : 0;
                end
            end
        end else if (m_mode == M_HALT) begin
            if (en && rs) m_mode = M_RUN;
        end
        e.je = j; e.ce = c; e.re = r;
        exp_q.push_back(e);
    endtask

    task automatic idle();                  step(1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic jmp(input logic [7:0] t); step(1, 1, 0, 0, 1, 0, 0, t, 8'h00);     endtask
    task automatic call(input logic [7:0] t); step(1, 0, 1, 0, 1, 0, 0, t, 8'h00);    endtask
    task automatic ret(input logic [7:0] a); step(1, 0, 0, 1, 1, 0, 0, 8'h00, a);     endtask

    initial begin
        async_rst = 1'b1;
        drive_idle();

        // Reset, then free-running increment
        do_reset();
        repeat (4) idle();

        // Call/return round trip from 0x10
        jmp(8'h10);
        call(8'h40);
        ret(8'h11);
        idle();

        // Untaken jump, then wrap from 0xFF
        jmp(8'h20);
        step(1, 1, 0, 0, 0, 0, 0, 8'h80, 8'h00);
        jmp(8'hFF);
        idle();
        idle();

        // Requests with clk_en low: strobes visible, nothing moves
        step(0, 1, 0, 0, 1, 0, 0, 8'h99, 8'h00);
        step(0, 0, 1, 0, 1, 0, 0, 8'h77, 8'h00);
        idle();

        // Fill the stack, then one call too many
        do_reset();
        for (int i = 0; i < SD; i++) call(8'(8'h50 + i));
        call(8'hE0);
        idle();
        ret(8'h33);
        idle();

        // Return at depth zero
        do_reset();
        ret(8'h44);
        idle();

        // Call and return together at 0x05
        do_reset();
        jmp(8'h05);
        step(1, 0, 1, 1, 1, 0, 0, 8'h60, 8'h61);
        idle();

        // Halt, hold, resume, and reset while halted
        do_reset();
        jmp(8'h30);
        step(1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        repeat (5) idle();
        step(1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        idle();
        idle();
        step(1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        idle();
        do_reset();
        idle();
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ((m_mode == M_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 2) == 0,
                     8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
            end
        end

        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound the whole run
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout actual=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crash_course_cpu_program_sequencer.md
# crash_course_cpu_program_sequencer

Program-counter sequencer for the crash-course CPU. It owns the 8-bit program counter and drives the control side of the call stack: it issues jump, call and return strobes and consumes the popped return address. It also tracks call depth so that stack overflow and underflow are caught before they corrupt the 8-entry stack.

## Interface
- `STACK_DEPTH`, default 8: number of call-stack entries; the overflow threshold.
- `clk`  in  1  clock.
- `async_rst`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  qualifies every state, PC and depth update.
- `jump_request`  in  1  decoded plain jump.
- `call_request`  in  1  decoded call.
- `return_request`  in  1  decoded return.
- `condition_met`  in  1  branch condition; a transfer is taken only when this is 1.
- `jump_target`  in  8  destination for jump and call.
- `return_address`  in  8  top of the call stack, combinational from the stack.
- `halt_request`  in  1  stop fetching.
- `resume_request`  in  1  leave HALT.
- `program_counter_current`  out  8  current PC.
- `jump_enable`  out  1  a control transfer is taken this cycle.
- `call_enable`  out  1  the taken transfer is a call.
- `return_enable`  out  1  the taken transfer is a return.
- `stack_depth`  out  4  live call depth, 0..STACK_DEPTH.
- `fault`  out  1  sequencer is in FAULT.
- `fault_code`  out  2  fault cause: 0 none, 1 overflow, 2 underflow, 3 call+return together.

## Operation
- States: RUN, HALT, FAULT.
- Reset values: `program_counter_current`=0x00, state RUN, `stack_depth`=0, `fault`=0, `fault_code`=0, all enables 0.
- The strobes are combinational and are 0 outside RUN.
  - `call_enable` = RUN & call_request & condition_met & legal.
  - `return_enable` = RUN & return_request & condition_met & legal.
  - `jump_enable` = `call_enable` | `return_enable` | (RUN & jump_request & condition_met & legal).
- `call_enable` and `return_enable` are never asserted together.
- PC update, RUN with `clk_en`=1 only:
  - taken call or jump: PC <= `jump_target`.
  - taken return: PC <= `return_address`.
  - otherwise: PC <= PC+1. Arithmetic is mod 256, so 0xFF wraps to 0x00.
- Jump request with condition_met=0: PC increments and no strobes are asserted.
- Depth update: taken call +1, taken return −1, plain jump unchanged.
- Illegal condition 1: call taken with depth==STACK_DEPTH (overflow).
- Illegal condition 2: return taken with depth==0 (underflow).
- Illegal condition 3: call_request and return_request both 1, regardless of condition_met.
- An illegal request suppresses all strobes and leaves PC and depth unchanged (guard build: see Configuration).
- Request priority when several are asserted: illegal > halt_request > call/return/jump.
- Transitions:
  - RUN→HALT on halt_request. PC holds, no strobes.
  - HALT→RUN on resume_request. Execution resumes at the held PC on the next enabled cycle.
  - RUN→FAULT on any illegal request (guard build only).
  - FAULT is exited only by `async_rst`; PC and depth freeze.
- All transitions require `clk_en`=1.

## Timing
- PC, depth and state are registered and change at the clk edge where `clk_en`=1.
- The strobes are valid in the same cycle as the requests. The call stack samples them on that edge, so:
  - a call stores the pre-edge PC+1;
  - a return pops in the same edge that loads `return_address` into PC.
- PC latency is 1 cycle from request to new PC.
- `fault` and `fault_code` assert on the edge after the illegal request and hold until reset.
- `async_rst` forces reset values immediately, including mid-transfer. Reset takes effect without a clock edge.
- With `clk_en`=0, all registers hold. The strobes remain combinational but have no effect downstream, because the stack also gates on `clk_en`.

## Configuration
- `CALL_STACK_GUARD_EN` defined (fault detection compiled in):
  - illegal conditions enter FAULT with the fault_code given above;
  - strobes are suppressed for the illegal request.
- `CALL_STACK_GUARD_EN` undefined (fault detection compiled out):
  - `fault` and `fault_code` are tied to 0 and the FAULT state is removed;
  - overflow call: the strobe issues and depth saturates at STACK_DEPTH;
  - underflow return: the strobe issues, PC loads `return_address`, and depth stays at 0;
  - simultaneous call+return: treated as no transfer, so PC+1 and no strobes.

## Test plan
- Reset, then 4 enabled idle cycles → PC 0x00,0x01,0x02,0x03,0x04; depth 0; no strobes.
- PC=0x10, call to 0x40 with condition_met=1 → jump_enable=call_enable=1 that cycle, PC=0x40, depth=1. Then return with return_address=0x11 → PC=0x11, depth=0.
- Jump to 0x80 with condition_met=0 at PC=0x20 → PC=0x21, no strobes. Run from PC=0xFF → PC=0x00.
- Guard build: 8 calls, then a 9th → 9th has no strobes, fault=1, fault_code=1, PC frozen. Then return at depth 0 after reset → fault_code=2.
- Call and return together at PC=0x05 → guard build: fault_code=3, no strobes. Non-guard build: PC=0x06, no strobes.
- halt_request at PC=0x30 → PC holds 0x30 for 5 cycles; resume_request → PC=0x31 next enabled edge. Assert async_rst mid-HALT → PC=0x00 immediately, state RUN.
